// File: rtl/request_manager.sv
// rtl/request_manager.sv - per-client pending-request counters feeding an external fixed-priority arbiter
// Holds one granted transaction at a time in SERVE until the downstream handshake retires it.
module request_manager #(
  parameter int NumRequests = 4,
  parameter int CntWidth    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NumRequests-1:0]         req_pulse,
  output logic [NumRequests-1:0]         request,
  input  logic [NumRequests-1:0]         grant,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NumRequests)-1:0] out_id,
  output logic [NumRequests-1:0]         overflow,
  output logic                           protocol_err
);

  localparam int IdW = $clog2(NumRequests);
  localparam logic [CntWidth-1:0] CntMax = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e                                state_q, state_d;
  logic                                  out_valid_q, out_valid_d;
  logic [IdW-1:0]                        out_id_q, out_id_d;
  logic [NumRequests-1:0][CntWidth-1:0]  pending_q, pending_d;
  logic [NumRequests-1:0]                overflow_q, overflow_d;
  logic                                  protocol_err_q, protocol_err_d;

  logic [NumRequests-1:0] pending_nz;
  logic                   grant_onehot;
  logic                   grant_legal;
  logic [IdW-1:0]         grant_idx;
  logic                   handshake;

  always_comb begin
    pending_nz = '0;
    grant_idx  = '0;
    for (int i = 0; i < NumRequests; i++) begin
      pending_nz[i] = (pending_q[i] != '0);
      if (grant[i]) grant_idx = IdW'(i);
    end
    grant_onehot = (grant != '0) &&
                   ((grant & (grant - NumRequests'(1))) == '0);
    grant_legal  = grant_onehot && ((grant & pending_nz) != '0);
    handshake    = (state_q == SERVE) && out_ready;
  end

  // Decoded only from flops so the external arbiter's grant cannot loop back into request.
  assign request      = (state_q == IDLE) ? pending_nz : '0;
  assign out_valid    = out_valid_q;
  assign out_id       = out_id_q;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;

  always_comb begin
    state_d        = state_q;
    out_valid_d    = out_valid_q;
    out_id_d       = out_id_q;
    protocol_err_d = protocol_err_q;
    case (state_q)
      IDLE: begin
        if (grant != '0) begin
          if (grant_legal) begin
            state_d     = SERVE;
            out_valid_d = 1'b1;
            out_id_d    = grant_idx;
          end else begin
            protocol_err_d = 1'b1;
          end
        end
      end
      SERVE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // A retire and a new request on the same client cancel, so saturation is only hit by a net increment.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NumRequests; i++) begin
      if (req_pulse[i] && !(handshake && out_id_q == IdW'(i))) begin
        if (pending_q[i] == CntMax) begin
          overflow_d[i] = 1'b1;
        end else begin
          pending_d[i] = pending_q[i] + CntWidth'(1);
        end
      end else if (!req_pulse[i] && handshake && out_id_q == IdW'(i)) begin
        if (pending_q[i] != '0) pending_d[i] = pending_q[i] - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      out_valid_q    <= 1'b0;
      out_id_q       <= '0;
      pending_q      <= '0;
      overflow_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      out_valid_q    <= out_valid_d;
      out_id_q       <= out_id_d;
      pending_q      <= pending_d;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_request_manager.sv
// tb/tb_request_manager.sv - directed self-checking bench for request_manager
// A fixed-priority (lowest index first) arbiter model closes the request/grant loop.
module tb_request_manager;

  logic       clk;
  logic       rst;
  logic [3:0] req_pulse;
  logic [3:0] request;
  logic [3:0] grant;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_id;
  logic [3:0] overflow;
  logic       protocol_err;

  logic       force_en;
  logic [3:0] forced_grant;
  logic [3:0] arb_grant;

  int checks;
  int failures;
  int n;

  request_manager #(.NumRequests(4), .CntWidth(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_pulse    (req_pulse),
    .request      (request),
    .grant        (grant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_id       (out_id),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign arb_grant = request & (~request + 4'd1);
  assign grant     = force_en ? forced_grant : arb_grant;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask);
    req_pulse = mask;
    tick();
    req_pulse = 4'b0000;
  endtask

  // Retires everything pending; returns the number of SERVE cycles seen (bounded).
  task automatic drain(output int served);
    served    = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) served++;
      if (!out_valid && request == 4'b0000) break;
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    req_pulse    = 4'b0000;
    out_ready    = 1'b0;
    force_en     = 1'b0;
    forced_grant = 4'b0000;

    #3;
    check("rst_request", int'(request), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_id", int'(out_id), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_protocol_err", int'(protocol_err), 0);
    tick();
    rst = 1'b0;

    // Two clients: lower index served first, then the other.
    pulse(4'b1010);
    check("two_request", int'(request), 4'b1010);
    tick();
    check("two_first_valid", int'(out_valid), 1);
    check("two_first_id", int'(out_id), 1);
    check("two_serve_request", int'(request), 0);
    out_ready = 1'b1;
    tick();
    check("two_after_first_request", int'(request), 4'b1000);
    tick();
    check("two_second_valid", int'(out_valid), 1);
    check("two_second_id", int'(out_id), 3);
    tick();
    out_ready = 1'b0;
    check("two_done_request", int'(request), 0);
    check("two_done_valid", int'(out_valid), 0);

    // Stall with out_id=2 and a junk grant that must be ignored in SERVE.
    pulse(4'b0100);
    pulse(4'b0100);
    check("stall_enter_valid", int'(out_valid), 1);
    check("stall_enter_id", int'(out_id), 2);
    force_en     = 1'b1;
    forced_grant = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_id", int'(out_id), 2);
      check("stall_request", int'(request), 0);
    end
    force_en = 1'b0;
    check("stall_no_err", int'(protocol_err), 0);
    drain(n);
    check("stall_pending_kept", n, 2);

    // Saturation of client 0 while stuck in SERVE.
    for (int k = 1; k <= 9; k++) begin
      pulse(4'b0001);
      check($sformatf("sat_overflow_%0d", k), int'(overflow[0]), (k >= 8) ? 1 : 0);
    end
    check("sat_id", int'(out_id), 0);
    drain(n);
    check("sat_served", n, 7);
    check("sat_overflow_sticky", int'(overflow), 4'b0001);

    // Increment and retire on the same client at the saturated value.
    for (int k = 0; k < 7; k++) pulse(4'b0010);
    check("simul_id", int'(out_id), 1);
    check("simul_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    req_pulse = 4'b0010;
    tick();
    req_pulse = 4'b0000;
    out_ready = 1'b0;
    check("simul_overflow", int'(overflow), 4'b0001);
    drain(n);
    check("simul_served", n, 7);
    check("simul_overflow_after", int'(overflow), 4'b0001);

    // Zero grant is benign; multi-bit and zero-pending grants are protocol errors.
    force_en     = 1'b1;
    forced_grant = 4'b0000;
    pulse(4'b0011);
    check("zero_grant_request", int'(request), 4'b0011);
    tick();
    tick();
    check("zero_grant_valid", int'(out_valid), 0);
    check("zero_grant_err", int'(protocol_err), 0);
    forced_grant = 4'b0011;
    tick();
    check("multi_grant_err", int'(protocol_err), 1);
    check("multi_grant_valid", int'(out_valid), 0);
    forced_grant = 4'b0100;
    tick();
    check("empty_grant_valid", int'(out_valid), 0);
    check("empty_grant_request", int'(request), 4'b0011);
    check("empty_grant_err", int'(protocol_err), 1);
    force_en = 1'b0;
    drain(n);
    check("illegal_served", n, 2);

    // Asynchronous reset in the middle of SERVE.
    pulse(4'b0100);
    pulse(4'b0100);
    pulse(4'b0100);
    check("rstmid_valid_before", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_valid", int'(out_valid), 0);
    check("rstmid_request", int'(request), 0);
    check("rstmid_overflow", int'(overflow), 0);
    check("rstmid_err", int'(protocol_err), 0);
    check("rstmid_id", int'(out_id), 0);
    tick();
    rst = 1'b0;
    pulse(4'b1000);
    check("rstmid_post_request", int'(request), 4'b1000);
    tick();
    check("rstmid_post_valid", int'(out_valid), 1);
    check("rstmid_post_id", int'(out_id), 3);
    drain(n);
    check("rstmid_served", n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/request_manager.md
REQUEST_MANAGER -- requirements
Module: request_manager

Interface
REQ-001 Parameter NumRequests, default 4: number of clients; the value SHALL be at least 2.
REQ-002 Parameter CntWidth, default 3: width of each client's pending-request counter; the value SHALL be at least 1.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req_pulse, input, NumRequests: one-cycle request event per client; bit i high enqueues one request for client i.
REQ-006 Port request, output, NumRequests: request vector to the fixed-priority arbiter; bit i high means client i has pending work.
REQ-007 Port grant, input, NumRequests: one-hot grant returned combinationally by the arbiter.
REQ-008 Port out_valid, output, 1: a granted transaction is presented downstream.
REQ-009 Port out_ready, input, 1: the downstream side accepts the transaction.
REQ-010 Port out_id, output, $clog2(NumRequests): index of the granted client, valid while out_valid is high.
REQ-011 Port overflow, output, NumRequests: sticky flag per client, set when that client's counter saturates.
REQ-012 Port protocol_err, output, 1: sticky flag set on an illegal grant.

Function
REQ-013 One counter per client SHALL hold pending[i], an unsigned value of CntWidth bits with maximum 2^CntWidth-1.
REQ-014 The FSM SHALL have two states:
- IDLE: accepts a grant.
- SERVE: holds a transaction until handshake.
REQ-015 In IDLE, request[i] SHALL equal (pending[i] != 0); in SERVE, request SHALL be all zeros.
REQ-016 In IDLE, a grant that is one-hot with its set bit on a client where pending is nonzero SHALL be accepted:
- latch out_id to the bit index;
- go to SERVE on the next edge.
REQ-017 In IDLE, a grant with more than one bit set, or with its bit on a client where pending is 0, SHALL be ignored, set protocol_err, and leave the state at IDLE.
REQ-018 In IDLE, an all-zero grant SHALL keep the state at IDLE with no error.
REQ-019 out_valid SHALL be high exactly while in SERVE, which starts one cycle after grant acceptance.
REQ-020 In SERVE, out_valid and out_id SHALL stay stable until out_ready is high.
REQ-021 A handshake (SERVE and out_ready) SHALL decrement pending[out_id] by 1 and return the FSM to IDLE on the same edge.
REQ-022 Back-to-back transactions SHALL therefore be separated by at least one IDLE cycle.
REQ-023 In SERVE, grant SHALL be ignored and SHALL NOT set protocol_err.
REQ-024 req_pulse[i] SHALL increment pending[i] on every edge, in any state.
REQ-025 When an increment and a handshake decrement hit the same client on the same edge, pending SHALL be unchanged and overflow SHALL NOT be set.
REQ-026 When pending[i] is at its maximum and req_pulse[i] arrives with no simultaneous decrement of client i:
- the increment SHALL be dropped;
- pending[i] SHALL hold its value;
- overflow[i] SHALL be set.
REQ-027 pending SHALL never wrap below 0 or above its maximum.
REQ-028 overflow and protocol_err SHALL clear only on reset.
REQ-029 request SHALL be decoded from registered state only, so the combinational arbiter path contains no loop.

Reset
REQ-030 While rst is high, the block SHALL hold:
- state IDLE;
- all pending counters 0;
- request 0, out_valid 0, out_id 0;
- overflow 0, protocol_err 0.
REQ-031 Reset asserted mid-SERVE SHALL drop out_valid immediately, asynchronously, and discard the transaction and all pending counts.
REQ-032 After rst deasserts, the first active edge SHALL be able to accept req_pulse.

Verification
REQ-033 Two-client acceptance: NumRequests=4, with the fixed-priority arbiter connected.
- Stimulus: req_pulse=4'b1010 for one cycle.
- Required response: request=4'b1010 on the next cycle; out_id=1 is served first; after its handshake out_id=3; request=0 after both handshakes.
REQ-034 Stall: in SERVE with out_id=2, hold out_ready=0 for 5 cycles.
- Required response: out_valid and out_id=2 stay stable, request=0, and pending[2] is unchanged until the handshake.
REQ-035 Saturation: CntWidth=3; pulse client 0 nine times with out_ready=0.
- Required response: pending[0]=7; overflow[0]=1 after the 8th pulse and stays set.
REQ-036 Simultaneous events: pending[1]=7 in SERVE with out_id=1; assert out_ready and req_pulse[1] on the same cycle.
- Required response: pending[1]=7 and overflow[1]=0.
REQ-037 Illegal grant: force grant=4'b0011, then grant=4'b0100 with pending[2]=0.
- Required response: the FSM stays IDLE, protocol_err=1, and no counter changes.
REQ-038 Reset mid-SERVE: assert rst while out_valid=1.
- Required response: out_valid=0 in the same cycle and all counters 0; after deassertion, one pulse on client 3 yields out_id=3.
